// File: rtl/addsub_serial_if.sv
// rtl/addsub_serial_if.sv - start/operand/result bundle for the digit-serial adder/subtractor
interface addsub_serial_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             borrow;
    logic             zero;
    logic             overflow;

    modport master (
        output start, op_sub, a, b,
        input  busy, done, result, carry, borrow, zero, overflow
    );

    modport slave (
        input  start, op_sub, a, b,
        output busy, done, result, carry, borrow, zero, overflow
    );
endinterface

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial two's-complement add/sub, LSD first; ADDSUB_SAT_EN selects saturating result
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic          clk,
    input logic          rst_n,
    addsub_serial_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [CW-1:0]    cnt;
    logic             c_q, op_q, a_s, b_s;

    logic             accept, last, r_s, ov;
    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] res_full, res_fin;

    logic             done_q, carry_q, borrow_q, zero_q, ov_q;
    logic [WIDTH-1:0] result_q;

    assign accept = (state == IDLE) && bus.start;
    assign last   = (cnt == CW'(N - 1));

    always_comb begin
        dsum     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
        // New slice enters at the top so after N shifts the LSD sits at bit 0.
        res_full = (res_sh >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        r_s      = res_full[WIDTH-1];
        ov       = op_q ? ((a_s != b_s) && (r_s != a_s))
                        : ((a_s == b_s) && (r_s != a_s));
`ifdef ADDSUB_SAT_EN
        res_fin  = ov ? (a_s ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : res_full;
`else
        res_fin  = res_full;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            cnt    <= '0;
            c_q    <= 1'b0;
            op_q   <= 1'b0;
            a_s    <= 1'b0;
            b_s    <= 1'b0;
        end else if (accept) begin
            // B is inverted and the carry seeded with op_sub: a - b == a + ~b + 1.
            a_sh   <= bus.a;
            b_sh   <= bus.b ^ {WIDTH{bus.op_sub}};
            c_q    <= bus.op_sub;
            op_q   <= bus.op_sub;
            a_s    <= bus.a[WIDTH-1];
            b_s    <= bus.b[WIDTH-1];
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            c_q    <= dsum[DIGIT];
            res_sh <= res_full;
            cnt    <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == RUN && last) begin
                done_q   <= 1'b1;
                result_q <= res_fin;
                carry_q  <= dsum[DIGIT];
                borrow_q <= op_q & ~dsum[DIGIT];
                zero_q   <= (res_fin == '0);
                ov_q     <= ov;
            end
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.borrow   = borrow_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ov_q;
endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - checks DIGIT=4/1/16 instances of addsub_serial against an arithmetic model
module tb_addsub_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addsub_serial_if #(.WIDTH(16)) if4 ();
    addsub_serial_if #(.WIDTH(16)) if1 ();
    addsub_serial_if #(.WIDTH(16)) if16 ();

    addsub_serial #(.WIDTH(16), .DIGIT(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    addsub_serial #(.WIDTH(16), .DIGIT(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    addsub_serial #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    int compared   = 0;
    int mismatched = 0;
    int lat4, lat1, lat16, busy4, dn4, dn1, dn16;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {carry, borrow, zero, overflow, result} from signed/unsigned integer arithmetic.
    function automatic logic [19:0] model(input bit op, input logic [15:0] av, input logic [15:0] bv);
        int sa, sb, t;
        logic [15:0] r;
        bit c, ov;
        sa = $signed(av);
        sb = $signed(bv);
        if (op) begin
            t = sa - sb;
            c = (av >= bv);
            r = av - bv;
        end else begin
            t = sa + sb;
            c = (int'(av) + int'(bv)) > 65535;
            r = av + bv;
        end
        ov = (t > 32767) || (t < -32768);
`ifdef ADDSUB_SAT_EN
        if (ov) r = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {c, op & ~c, (r == 16'h0), ov, r};
    endfunction

    task automatic drive(input bit st, input bit op, input logic [15:0] av, input logic [15:0] bv);
        if4.start  = st; if4.op_sub  = op; if4.a  = av; if4.b  = bv;
        if1.start  = st; if1.op_sub  = op; if1.a  = av; if1.b  = bv;
        if16.start = st; if16.op_sub = op; if16.a = av; if16.b = bv;
    endtask

    task automatic begin_op(input bit op, input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        drive(1'b1, op, av, bv);
        @(negedge clk);
        drive(1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic wait_all();
        lat4 = 0; lat1 = 0; lat16 = 0; dn4 = 0; dn1 = 0; dn16 = 0;
        busy4 = if4.busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            if (lat4 != 0 && lat1 != 0 && lat16 != 0) break;
            @(negedge clk);
            if (if4.done)  begin dn4++;  if (lat4 == 0)  lat4 = i;  end
            if (if1.done)  begin dn1++;  if (lat1 == 0)  lat1 = i;  end
            if (if16.done) begin dn16++; if (lat16 == 0) lat16 = i; end
            if (lat4 == 0 && if4.busy) busy4++;
        end
    endtask

    task automatic chk_out(input string tag, input int lat, input int explat, input int dn,
                           input logic [19:0] obs, input logic [19:0] exp);
        chk({tag, "_lat"},   32'(lat), 32'(explat));
        chk({tag, "_pulse"}, 32'(dn), 32'd1);
        chk({tag, "_res"},   32'(obs[15:0]), 32'(exp[15:0]));
        chk({tag, "_flags"}, 32'(obs[19:16]), 32'(exp[19:16]));
    endtask

    task automatic run_op(input string tag, input bit op, input logic [15:0] av, input logic [15:0] bv);
        logic [19:0] e;
        e = model(op, av, bv);
        begin_op(op, av, bv);
        wait_all();
        chk({tag, "_busy4"}, 32'(busy4), 32'd4);
        chk_out({tag, "_d4"},  lat4,  4,  dn4,
                {if4.carry, if4.borrow, if4.zero, if4.overflow, if4.result}, e);
        chk_out({tag, "_d1"},  lat1,  16, dn1,
                {if1.carry, if1.borrow, if1.zero, if1.overflow, if1.result}, e);
        chk_out({tag, "_d16"}, lat16, 1,  dn16,
                {if16.carry, if16.borrow, if16.zero, if16.overflow, if16.result}, e);
    endtask

    initial begin
        logic [19:0] e;
        int lat, cnt;

        drive(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        chk("reset_d4",  32'({if4.busy, if4.done, if4.carry, if4.borrow, if4.zero, if4.overflow, if4.result}), 32'd0);
        chk("reset_d1",  32'({if1.busy, if1.done, if1.carry, if1.borrow, if1.zero, if1.overflow, if1.result}), 32'd0);
        chk("reset_d16", 32'({if16.busy, if16.done, if16.carry, if16.borrow, if16.zero, if16.overflow, if16.result}), 32'd0);
        rst_n = 1'b1;

        run_op("sub_5_3",       1'b1, 16'h0005, 16'h0003);
        run_op("sub_3_5",       1'b1, 16'h0003, 16'h0005);
        run_op("sub_eq",        1'b1, 16'h1234, 16'h1234);
        run_op("add_ovf",       1'b0, 16'h7FFF, 16'h0001);
        run_op("add_wrap",      1'b0, 16'hFFFF, 16'h0001);
        run_op("sub_ovf",       1'b1, 16'h8000, 16'h0001);
        run_op("add_1234_4321", 1'b0, 16'h1234, 16'h4321);
        run_op("sub_min_min",   1'b1, 16'h8000, 16'h8000);
        run_op("sub_0_min",     1'b1, 16'h0000, 16'h8000);

        for (int k = 0; k < 24; k++)
            run_op("rand", 1'($urandom), 16'($urandom), 16'($urandom));

        // Starts during a run must be ignored by the DIGIT=4 instance.
        begin_op(1'b1, 16'h0005, 16'h0003);
        @(negedge clk); drive(1'b1, 1'b0, 16'hAAAA, 16'h5555);
        @(negedge clk); drive(1'b1, 1'b1, 16'h1111, 16'h2222);
        @(negedge clk); drive(1'b0, 1'b0, 16'h0, 16'h0);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (if4.done) begin lat = 3 + i; break; end
        end
        chk("ign_lat", 32'(lat), 32'd4);
        chk("ign_res", 32'(if4.result), 32'h0002);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if4.done || if4.busy) cnt++;
        end
        chk("ign_quiet", 32'(cnt), 32'd0);
        repeat (20) @(negedge clk);

        // start held through the done cycle chains a second operation with no gap.
        begin_op(1'b0, 16'h1111, 16'h2222);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            if (if4.done) begin lat = i; break; end
            @(negedge clk);
        end
        chk("b2b_first_seen", 32'(lat != 0), 32'd1);
        chk("b2b_first_res", 32'(if4.result), 32'h3333);
        drive(1'b1, 1'b1, 16'h0100, 16'h0001);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (if4.done) begin lat = i; break; end
        end
        e = model(1'b1, 16'h0100, 16'h0001);
        chk("b2b_second_lat", 32'(lat), 32'd4);
        chk("b2b_second_res", 32'(if4.result), 32'(e[15:0]));
        chk("b2b_second_flags", 32'({if4.carry, if4.borrow, if4.zero, if4.overflow}), 32'(e[19:16]));
        repeat (20) @(negedge clk);

        // Asynchronous reset mid-run clears outputs at once and suppresses done.
        begin_op(1'b0, 16'h7FFF, 16'h0001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_d4",  32'({if4.busy, if4.done, if4.carry, if4.borrow, if4.zero, if4.overflow, if4.result}), 32'd0);
        chk("rst_mid_d1",  32'({if1.busy, if1.done, if1.carry, if1.borrow, if1.zero, if1.overflow, if1.result}), 32'd0);
        chk("rst_mid_d16", 32'({if16.busy, if16.done, if16.carry, if16.borrow, if16.zero, if16.overflow, if16.result}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if4.done || if1.done || if16.done || if4.busy || if1.busy || if16.busy) cnt++;
        end
        chk("rst_no_done", 32'(cnt), 32'd0);

        run_op("post_rst", 1'b0, 16'h1234, 16'h4321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle two's-complement adder/subtractor for the processor datapath, generalising the fixed 8-bit ripple subtractor. Operands are latched on a start handshake and processed DIGIT bits per clock, least-significant digit first. Correct borrow handling (a + ~b + 1) is included, along with registered carry/borrow/zero/overflow flags. It sits between the register file read ports and the ALU result mux, so wide operations trade latency for area.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT, ≥ 2
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; **asynchronous, active-low**
- start  in  1  request; sampled only when busy=0
- op_sub  in  1  0 = a+b, 1 = a−b; latched with operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result and flags valid
- result  out  WIDTH  sum/difference; held until next accepted start
- carry  out  1  unsigned carry-out of final digit (sub: 1 = no borrow)
- borrow  out  1  sub only: ~carry (a < b unsigned); 0 for add
- zero  out  1  result == 0
- overflow  out  1  signed overflow of the true operation

## Operation
- States: IDLE, RUN.
  - IDLE → RUN on start=1. Latch a, b^{WIDTH{op_sub}} and op_sub. Set digit counter to 0 and internal carry to op_sub.
  - RUN, each cycle: add the current DIGIT slice of A, B' and carry. Shift the sum slice into the result shift register. Update carry. Increment the counter.
  - RUN → IDLE after the slice with counter = WIDTH/DIGIT−1. On that edge: register result and flags, and pulse done.
- Flags are computed from latched sign bits and the final result:
  - add overflow = (a_s == b_s) & (r_s ≠ a_s)
  - sub overflow = (a_s ≠ b_s) & (r_s ≠ a_s)
- start while busy=1 is ignored; no queueing and no error.
- The a, b and op_sub inputs may change freely after the accept edge.
- Reset (any time, including mid-RUN):
  - State → IDLE.
  - busy, done, result, carry, borrow, zero, overflow all → 0.
  - The aborted operation produces no done.

## Timing
- Accept edge E0 (start=1, busy=0): busy=1 from E0.
- Let N = WIDTH/DIGIT. After edge EN: done=1 for exactly one cycle, busy=0, result and flags valid.
- Latency N cycles; throughput one operation per N cycles.
- The result and flags outputs change only on the done edge or on reset.
- start=1 in the done cycle is accepted (busy=0 there). Back-to-back operations therefore have no idle gap.
- DIGIT = WIDTH gives single-cycle latency: done one edge after accept.

## Configuration
- ADDSUB_SAT_EN defined:
  - On overflow=1, result clamps to 0x7F…F if a_s=0, or 0x80…0 if a_s=1.
  - overflow still reports 1.
  - zero is evaluated on the clamped result.
- ADDSUB_SAT_EN undefined: result wraps modulo 2^WIDTH.

## Test plan
All cases WIDTH=16, DIGIT=4 unless stated.
- Sub 0x0005−0x0003 → result 0x0002, carry 1, borrow 0, zero 0, overflow 0. done exactly 4 cycles after accept; busy high for those 4 cycles.
- Sub 0x0003−0x0005 → 0xFFFE, borrow 1, carry 0, overflow 0. Sub 0x1234−0x1234 → 0x0000, zero 1, borrow 0.
- Add 0x7FFF+0x0001 → overflow 1.
  - Without ADDSUB_SAT_EN: result 0x8000.
  - With ADDSUB_SAT_EN: result 0x7FFF.
- Add 0xFFFF+0x0001 → 0x0000, carry 1, zero 1, overflow 0. Sub 0x8000−0x0001 → overflow 1 (0x7FFF wrapped; 0x8000 saturated).
- Control handshake:
  - start pulsed on cycles 2 and 3 of a run with new operands: ignored, first result intact.
  - start held high in the done cycle: second operation accepted, its done 4 cycles later.
  - rst_n low mid-RUN: all outputs 0 immediately, no done.
- Parameter sweep DIGIT=1 and DIGIT=16 on WIDTH=16: add 0x1234+0x4321 → 0x5555, latency 16 and 1 cycles respectively.
